// File: rtl/div_pkg.sv
// Shared widths and the result payload carried by the second pipeline stage
// of the 16/8 unsigned divider.
package div_pkg;
  localparam int DIVIDEND_W   = 16;
  localparam int DIVISOR_W    = 8;
  localparam int PIPE_LATENCY = 2;

  typedef struct packed {
    logic [DIVIDEND_W-1:0] quot;
    logic [DIVIDEND_W-1:0] rem;
    logic                  dz;
  } s2_payload_t;
endpackage

// File: rtl/div_16bit.sv
// Purely combinational 16-bit by 8-bit unsigned divider (restoring long
// division). A zero divisor yields quotient 0, remainder = dividend, dz = 1.
module div_16bit
  import div_pkg::*;
(
  input  logic [DIVIDEND_W-1:0] a_i,
  input  logic [DIVISOR_W-1:0]  b_i,
  output s2_payload_t           res_o
);

  // One extra bit so the shifted partial remainder cannot overflow before the compare.
  logic [DIVISOR_W:0]    part_v;
  logic [DIVIDEND_W-1:0] quot_v;

  always_comb begin
    part_v = '0;
    quot_v = '0;
    for (int i = DIVIDEND_W - 1; i >= 0; i--) begin
      part_v = {part_v[DIVISOR_W-1:0], a_i[i]};
      if (part_v >= {1'b0, b_i}) begin
        part_v    = part_v - {1'b0, b_i};
        quot_v[i] = 1'b1;
      end
    end
  end

  always_comb begin
    res_o = '0;
    if (b_i == '0) begin
      res_o.quot = '0;
      res_o.rem  = a_i;
      res_o.dz   = 1'b1;
    end else begin
      res_o.quot = quot_v;
      res_o.rem  = {{(DIVIDEND_W-DIVISOR_W){1'b0}}, part_v[DIVISOR_W-1:0]};
      res_o.dz   = 1'b0;
    end
  end

endmodule

// File: rtl/div_16bit_pipe.sv
// Two-stage valid/ready wrapper around div_16bit: S1 holds operands, S2 holds
// the registered result, plus completion and divide-by-zero counters.
module div_16bit_pipe
  import div_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] in_a,
  input  logic [DIVISOR_W-1:0]  in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] out_result,
  output logic [DIVIDEND_W-1:0] out_odd,
  output logic                  out_div_by_zero,
  output logic [CNT_W-1:0]      done_cnt,
  output logic [CNT_W-1:0]      dz_cnt,
  output logic                  busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Ready never depends on the matching valid, so producer and consumer
  // may wait on each other without forming a combinational loop.

  // vld_q[0] is S1 valid, vld_q[PIPE_LATENCY-1] is S2 valid.
  logic [PIPE_LATENCY-1:0] vld_q, vld_d;
  logic [DIVIDEND_W-1:0]   a_q, a_d;
  logic [DIVISOR_W-1:0]    b_q, b_d;
  s2_payload_t             s2_q, s2_d, div_res;
  logic [CNT_W-1:0]        done_cnt_q, done_cnt_d;
  logic [CNT_W-1:0]        dz_cnt_q, dz_cnt_d;

  logic s1_valid, s2_valid, s2_load, in_fire, out_fire;

  div_16bit u_div (
    .a_i   (a_q),
    .b_i   (b_q),
    .res_o (div_res)
  );

  assign s1_valid = vld_q[0];
  assign s2_valid = vld_q[PIPE_LATENCY-1];
  assign s2_load  = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid && out_ready;

  always_comb begin
    vld_d      = vld_q;
    a_d        = a_q;
    b_d        = b_q;
    s2_d       = s2_q;
    done_cnt_d = done_cnt_q;
    dz_cnt_d   = dz_cnt_q;

    // S1 refills in the same edge it drains into S2.
    if (in_fire) begin
      vld_d[0] = 1'b1;
      a_d      = in_a;
      b_d      = in_b;
    end else if (s2_load) begin
      vld_d[0] = 1'b0;
    end

    // A load replaces S2 even while its old result is leaving: no bubble.
    if (s2_load) begin
      vld_d[PIPE_LATENCY-1] = 1'b1;
      s2_d                  = div_res;
    end else if (out_fire) begin
      vld_d[PIPE_LATENCY-1] = 1'b0;
    end

    if (out_fire) begin
      done_cnt_d = done_cnt_q + 1'b1;
      if (s2_q.dz && (dz_cnt_q != {CNT_W{1'b1}})) begin
        dz_cnt_d = dz_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      s2_q       <= '0;
      done_cnt_q <= '0;
      dz_cnt_q   <= '0;
    end else begin
      vld_q      <= vld_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s2_q       <= s2_d;
      done_cnt_q <= done_cnt_d;
      dz_cnt_q   <= dz_cnt_d;
    end
  end

  assign out_valid       = s2_valid;
  assign out_result      = s2_q.quot;
  assign out_odd         = s2_q.rem;
  assign out_div_by_zero = s2_q.dz;
  assign done_cnt        = done_cnt_q;
  assign dz_cnt          = dz_cnt_q;
  assign busy            = |vld_q;

endmodule

// File: doc/div_16bit_pipe.md
DIV_16BIT_PIPE -- requirements
Module: div_16bit_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The block SHALL have parameter CNT_W, default 16, which sets the width of the statistics counters.
REQ-003 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  Asynchronous active-low reset.
REQ-005 in_valid  input  1  Operand pair present.
REQ-006 in_ready  output  1  Block can accept the operand pair this cycle.
REQ-007 in_a  input  16  Dividend.
REQ-008 in_b  input  8  Divisor.
REQ-009 out_valid  output  1  Result present.
REQ-010 out_ready  input  1  Consumer accepts the result this cycle.
REQ-011 out_result  output  16  Quotient.
REQ-012 out_odd  output  16  Remainder.
REQ-013 out_div_by_zero  output  1  Result came from in_b == 0.
REQ-014 done_cnt  output  CNT_W  Count of completed output handshakes.
REQ-015 dz_cnt  output  CNT_W  Count of completed divide-by-zero output handshakes.
REQ-016 busy  output  1  High when either pipeline stage holds valid data.

Function
REQ-017 Input transfer SHALL occur on a rising edge where in_valid && in_ready; output transfer SHALL occur where out_valid && out_ready.
REQ-018 The pipeline SHALL have two register stages: S1 (operands + s1_valid) and S2 (quotient, remainder, dz flag + s2_valid).
REQ-019 Divide SHALL be combinational between S1 and S2 and registered into S2.
REQ-020 Latency: an operand pair accepted at edge N SHALL produce out_valid=1 after edge N+1, with no stalls.
REQ-021 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-022 S2 SHALL load when S1 is valid and (!s2_valid || out_ready).
REQ-023 in_ready SHALL equal !s1_valid || (S2 can load this cycle); it is combinational and has no dependency on in_valid.
REQ-024 While stalled, S1/S2 contents and all out_* signals SHALL hold stable; no operation is dropped or duplicated, and order is preserved.
REQ-025 Arithmetic for in_b != 0: out_result = floor(in_a/in_b) and out_odd = in_a mod in_b; unsigned; quotient zero-extended to 16 bits; remainder < in_b.
REQ-026 Arithmetic for in_b == 0: out_result = 0, out_odd = in_a, out_div_by_zero = 1.
REQ-027 done_cnt SHALL increment by 1 on each output transfer and wrap from all-ones to 0.
REQ-028 dz_cnt SHALL increment on each output transfer with out_div_by_zero = 1 and saturate at all-ones.
REQ-029 Simultaneous output transfer and S1→S2 load SHALL replace S2 in the same edge, with no bubble.
REQ-030 Simultaneous input transfer and S1→S2 load SHALL refill S1 in the same edge.

Reset
REQ-031 On rst_n low, asynchronously: s1_valid=0, s2_valid=0, out_valid=0, busy=0, done_cnt=0, dz_cnt=0, out_result=0, out_odd=0, out_div_by_zero=0; in_ready=1 once reset is asserted.
REQ-032 Reset mid-operation SHALL discard all in-flight operations with no output transfer, and counters SHALL NOT count them.
REQ-033 After rst_n deasserts, the first input transfer SHALL be possible on the first rising edge.

Structure
REQ-034 Package div_pkg SHALL hold the constants DIVIDEND_W=16, DIVISOR_W=8 and PIPE_LATENCY=2, plus a packed struct for the S2 payload (quotient, remainder, dz).
REQ-035 The existing combinational divider div_16bit SHALL be instantiated once as the sole sub-module between S1 and S2; handshake and counters stay in div_16bit_pipe.

Verification
REQ-036 Basic divide: a=1000, b=7, out_ready=1 → out_valid one cycle after acceptance; result=142, odd=6, dz=0; done_cnt=1.
REQ-037 Divide by zero: a=0x1234, b=0 → result=0x0000, odd=0x1234, dz=1; dz_cnt=1.
REQ-038 Max operands: a=0xFFFF, b=0xFF → result=0x0101, odd=0x0000.
REQ-039 Streaming with backpressure: four back-to-back pairs (100/3, 50/0, 7/9, 65535/1) with out_ready low for 5 cycles. Required: in_ready drops after 2 accepts; results emerge in order as (33,1), (0,50,dz), (0,7), (65535,0); done_cnt=4, dz_cnt=1.
REQ-040 Reset mid-operation: assert rst_n low with both stages valid → out_valid=0 and counters=0 immediately; no stale result appears after release.
REQ-041 Counter wrap with CNT_W=4: 17 transfers → done_cnt=1; 17 divide-by-zero transfers → dz_cnt=15 (saturated).
